// File: rtl/pixel_packer.sv
// pixel_packer: packs a 24-bit RGB pixel stream into 32-bit words (4 pixels -> 3 words)
// and emits them on a valid/ready stream with start-of-frame (user) and end-of-line
// (last) sidebands. Lines whose width is not a multiple of 4 end with a zero-padded word.
// Optional statistics (frame_count, align_err) are built when PIXEL_PACKER_STATS_EN is defined.
module pixel_packer #(
   parameter int PIXEL_WIDTH = 24,   // only 24 is supported
   parameter int WORD_WIDTH  = 32,   // only 32 is supported
   parameter int BUF_DEPTH   = 2     // output buffer entries, 2..4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            r,
   input  logic [7:0]            g,
   input  logic [7:0]            b,
   input  logic                  in_valid,
   input  logic                  in_first,
   input  logic                  in_last_x,
   input  logic                  in_last_y,
   output logic                  in_ready,
   output logic [WORD_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_user,
   output logic                  out_last
`ifdef PIXEL_PACKER_STATS_EN
   ,
   output logic [15:0]           frame_count,
   output logic                  align_err
`endif
);

   localparam int PW = $clog2(BUF_DEPTH);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
   localparam ptr_t          LAST_PTR = PW'(BUF_DEPTH - 1);

   typedef enum logic {RUN, FLUSH} state_t;

   typedef struct packed {
      logic [WORD_WIDTH-1:0] data;
      logic                  user;
      logic                  last;
   } entry_t;

   state_t                 state;
   logic [1:0]             ph;
   logic [1:0]             eff_ph;
   logic [PIXEL_WIDTH-1:0] pix;
   logic [PIXEL_WIDTH-1:0] hold;
   logic                   pend_user;

   entry_t                 mem [BUF_DEPTH];
   ptr_t                   wr_ptr;
   ptr_t                   rd_ptr;
   logic [CW-1:0]          count;

   logic                   has_room;
   logic                   in_fire;
   logic                   out_fire;
   logic                   push;
   entry_t                 push_entry;

   assign pix      = {b, g, r};
   assign has_room = (count < DEPTH_C);
   // in_ready depends only on registered state and reset, never on out_ready
   assign in_ready = (state == RUN) && has_room && !reset;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;
   // a pixel starting a frame restarts the 4-pixel group, discarding any partial hold
   assign eff_ph   = in_first ? 2'd0 : ph;

   // Select the word (if any) produced this cycle: the flush word or the packed pixel
   // NOTE: every signal assigned in always_comb gets a default first, otherwise a path
   // that skips the assignment infers a latch.
   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (state == FLUSH) begin
         // ph is 2 when 16 bits of hold remain, 3 when 8 bits remain
         push            = has_room;
         push_entry.last = 1'b1;
         push_entry.data = (ph == 2'd2) ? {16'h0, hold[15:0]} : {24'h0, hold[7:0]};
      end else if (in_fire) begin
         unique case (eff_ph)
            2'd0: begin
               push            = in_last_x;
               push_entry.data = {8'h0, pix};
               push_entry.last = in_last_x;
            end
            2'd1: begin
               push            = 1'b1;
               push_entry.data = {pix[7:0], hold};
            end
            2'd2: begin
               push            = 1'b1;
               push_entry.data = {pix[15:0], hold[15:0]};
            end
            2'd3: begin
               push            = 1'b1;
               push_entry.data = {pix, hold[7:0]};
               push_entry.last = in_last_x;
            end
         endcase
      end
      push_entry.user = pend_user || (in_fire && in_first);
   end

   // Packing FSM: phase, holding register, pending start-of-frame flag, RUN/FLUSH
   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         ph        <= 2'd0;
         hold      <= '0;
         pend_user <= 1'b0;
      end else begin
         if (push) begin
            pend_user <= 1'b0;
         end else if (in_fire && in_first) begin
            pend_user <= 1'b1;
         end

         if (state == FLUSH) begin
            if (has_room) begin
               state <= RUN;
               ph    <= 2'd0;
            end
         end else if (in_fire) begin
            unique case (eff_ph)
               2'd0: hold <= pix;
               2'd1: hold <= {8'h0, pix[23:8]};
               2'd2: hold <= {16'h0, pix[23:16]};
               2'd3: hold <= '0;
            endcase
            if (in_last_x) begin
               if (eff_ph == 2'd1 || eff_ph == 2'd2) begin
                  ph    <= eff_ph + 2'd1;
                  state <= FLUSH;
               end else begin
                  ph <= 2'd0;
               end
            end else begin
               ph <= eff_ph + 2'd1;
            end
         end
      end
   end

   // Output FIFO bookkeeping: pointers and occupancy
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
         end
         if (out_fire) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, out_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output FIFO storage
   // NOTE: the storage array has no reset; entries are only visible while count covers
   // them, and the outputs are gated to zero when the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr].data : '0;
   assign out_user  = out_valid && mem[rd_ptr].user;
   assign out_last  = out_valid && mem[rd_ptr].last;

`ifdef PIXEL_PACKER_STATS_EN
   logic flush_last_y;
   logic line_last_y;

   // the flush word belongs to the pixel accepted before FLUSH, so its last_y is remembered
   assign line_last_y = (state == FLUSH) ? flush_last_y : in_last_y;

   // Frame counter and sticky alignment error
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count  <= '0;
         align_err    <= 1'b0;
         flush_last_y <= 1'b0;
      end else begin
         if (in_fire) begin
            flush_last_y <= in_last_y;
         end
         if (push && push_entry.last && line_last_y) begin
            frame_count <= frame_count + 16'd1;
         end
         if (in_fire && in_first && (ph != 2'd0 || state == FLUSH)) begin
            align_err <= 1'b1;
         end
      end
   end
`else
   logic unused_last_y;
   assign unused_last_y = in_last_y;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed and randomized stimulus for pixel_packer, checked against a
// byte-stream reference model (pixels become little-endian bytes, 4 bytes per word,
// zero padding at end of line).
module tb_pixel_packer;

   localparam int BUF_DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  r, g, b;
   logic        in_valid, in_first, in_last_x, in_last_y;
   logic        in_ready;
   logic [31:0] out_data;
   logic        out_valid, out_ready, out_user, out_last;
`ifdef PIXEL_PACKER_STATS_EN
   logic [15:0] frame_count;
   logic        align_err;
`endif

   always #5 clk = ~clk;

   pixel_packer #(.BUF_DEPTH(BUF_DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .r         (r),
      .g         (g),
      .b         (b),
      .in_valid  (in_valid),
      .in_first  (in_first),
      .in_last_x (in_last_x),
      .in_last_y (in_last_y),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_user  (out_user),
      .out_last  (out_last)
`ifdef PIXEL_PACKER_STATS_EN
      ,
      .frame_count (frame_count),
      .align_err   (align_err)
`endif
   );

   int          total = 0;
   int          bad   = 0;

   // reference model state
   logic [7:0]  bq[$];      // bytes accepted but not yet in an emitted word
   logic [33:0] exp_q[$];   // expected words {data, user, last}
   logic [33:0] got[$];     // words observed, for directed spot checks
   bit          pend;
   int          frames;
   bit          align_exp;
   bit          rand_ready = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      bq.delete();
      exp_q.delete();
      pend      = 1'b0;
      frames    = 0;
      align_exp = 1'b0;
   endtask

   task automatic emit(input logic [31:0] w, input bit last);
      exp_q.push_back({w, pend, last});
      pend = 1'b0;
   endtask

   task automatic model_pixel(input logic [23:0] p, input bit first, input bit lx, input bit ly);
      logic [31:0] w;
      if (first) begin
         if (bq.size() != 0) align_exp = 1'b1;
         bq.delete();
         pend = 1'b1;
      end
      bq.push_back(p[7:0]);
      bq.push_back(p[15:8]);
      bq.push_back(p[23:16]);
      while (bq.size() >= 4) begin
         w = '0;
         for (int i = 0; i < 4; i++) w[8*i +: 8] = bq.pop_front();
         emit(w, lx && bq.size() == 0);
      end
      if (lx && bq.size() != 0) begin
         w = '0;
         for (int i = 0; bq.size() != 0; i++) w[8*i +: 8] = bq.pop_front();
         emit(w, 1'b1);
      end
      if (lx && ly) frames++;
   endtask

   // compare any output transfer and feed any input transfer of the coming edge
   task automatic observe();
      logic [33:0] e;
      if (!reset && out_valid && out_ready) begin
         got.push_back({out_data, out_user, out_last});
         check("word_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_data", out_data, e[33:2]);
            check("out_user", out_user, e[1]);
            check("out_last", out_last, e[0]);
         end
      end
      if (!reset && in_valid && in_ready) model_pixel({b, g, r}, in_first, in_last_x, in_last_y);
   endtask

   task automatic tick(output bit rdy);
      @(negedge clk);
      rdy = in_ready;
      observe();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pixel(input logic [23:0] p, input bit first, input bit lx, input bit ly,
                             output int stalls);
      bit rdy;
      bit acc = 1'b0;
      {b, g, r} = p;
      in_first  = first;
      in_last_x = lx;
      in_last_y = ly;
      in_valid  = 1'b1;
      stalls    = 0;
      for (int k = 0; k < 60 && !acc; k++) begin
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         tick(rdy);
         if (rdy) acc = 1'b1;
         else stalls++;
      end
      if (!acc) check("accept_timeout", in_ready, 1);
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last_x = 1'b0;
      in_last_y = 1'b0;
   endtask

   task automatic drain();
      bit rdy;
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      in_valid   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (exp_q.size() == 0 && !out_valid) break;
         tick(rdy);
      end
      check("drain_empty", exp_q.size(), 0);
      check("drain_idle", out_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          st;
      int          zeros;
      bit          rdy;
      int          w;
      bit          f;
      logic [23:0] px [4];
      logic [23:0] xp;

      reset = 1'b1;
      {r, g, b} = '0;
      in_valid = 1'b0; in_first = 1'b0; in_last_x = 1'b0; in_last_y = 1'b0;
      out_ready = 1'b1;
      model_reset();

      // reset values
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_user", out_user, 0);
      check("rst_out_last", out_last, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // one 4-pixel group, first on pixel 0, last_x on pixel 3
      got.delete();
      px[0] = 24'h030201; px[1] = 24'h060504; px[2] = 24'h090807; px[3] = 24'h0C0B0A;
      for (int i = 0; i < 4; i++) begin
         send_pixel(px[i], i == 0, i == 3, 1'b0, st);
         check("t1_stall", st, 0);
      end
      drain();
      check("t1_count", got.size(), 3);
      check("t1_w0", got[0], {32'h04030201, 1'b1, 1'b0});
      check("t1_w1", got[1], {32'h08070605, 1'b0, 1'b0});
      check("t1_w2", got[2], {32'h0C0B0A09, 1'b0, 1'b1});

      // line of 6 pixels: last_x lands at ph1, one FLUSH cycle
      got.delete();
      for (int i = 0; i < 6; i++) send_pixel(24'($urandom()), 1'b0, i == 5, 1'b0, st);
      zeros = 0;
      for (int k = 0; k < 4; k++) begin
         tick(rdy);
         if (!rdy) zeros++;
      end
      check("t2_flush_stall", zeros, 1);
      drain();
      check("t2_count", got.size(), 5);
      check("t2_last_hi", got[4][33:18], 0);
      check("t2_last_flag", got[4][0], 1);
      check("t2_prev_flag", got[3][0], 0);

      // backpressure: in_ready drops once BUF_DEPTH words are buffered
      got.delete();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_pixel(24'($urandom()), i == 0, 1'b0, 1'b0, st);
         check("t3_stall", st, 0);
      end
      for (int k = 0; k < 3; k++) begin
         tick(rdy);
         check("t3_in_ready_low", rdy, 0);
         check("t3_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      for (int i = 3; i < 8; i++) send_pixel(24'($urandom()), 1'b0, i == 7, 1'b0, st);
      drain();
      check("t3_count", got.size(), 6);

      // in_first at ph2 drops the partial group
      got.delete();
      xp = 24'($urandom());
      send_pixel(24'($urandom()), 1'b1, 1'b0, 1'b0, st);
      send_pixel(24'($urandom()), 1'b0, 1'b0, 1'b0, st);
      send_pixel(xp, 1'b1, 1'b0, 1'b0, st);
      send_pixel(24'($urandom()), 1'b0, 1'b1, 1'b0, st);
      drain();
      check("t4_count", got.size(), 3);
      check("t4_user", got[1][1], 1);
      check("t4_new_pixel", got[1][25:2], xp);
`ifdef PIXEL_PACKER_STATS_EN
      check("t4_align_err", align_err, 1);
`endif

      // reset asserted while in FLUSH
      send_pixel(24'($urandom()), 1'b1, 1'b0, 1'b0, st);
      send_pixel(24'($urandom()), 1'b0, 1'b1, 1'b0, st);
      reset = 1'b1;
      model_reset();
      @(negedge clk);
      check("t5_in_ready_rst", in_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("t5_out_valid", out_valid, 0);
      check("t5_in_ready", in_ready, 1);
`ifdef PIXEL_PACKER_STATS_EN
      check("t5_align_clr", align_err, 0);
      check("t5_frames_clr", frame_count, 0);
`endif
      @(posedge clk); #1;
      got.delete();
      for (int i = 0; i < 4; i++) send_pixel(24'($urandom()), 1'b0, i == 3, 1'b0, st);
      drain();
      check("t5_count", got.size(), 3);
      check("t5_user", got[0][1], 0);

      // three frames of 8x2 pixels
      for (int fr = 0; fr < 3; fr++)
         for (int y = 0; y < 2; y++)
            for (int x = 0; x < 8; x++)
               send_pixel(24'($urandom()), x == 0 && y == 0, x == 7, x == 7 && y == 1, st);
      drain();
`ifdef PIXEL_PACKER_STATS_EN
      check("t6_frame_count", frame_count, 3);
`endif

      // randomized lines, first flags, gaps and out_ready
      rand_ready = 1'b1;
      for (int ln = 0; ln < 40; ln++) begin
         w = $urandom_range(1, 9);
         for (int x = 0; x < w; x++) begin
            if ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               out_ready = 1'($urandom_range(0, 1));
               tick(rdy);
            end
            f = (x == 0 && $urandom_range(0, 3) == 0) || ($urandom_range(0, 15) == 0);
            send_pixel(24'($urandom()), f, x == w - 1,
                       x == w - 1 && $urandom_range(0, 2) == 0, st);
         end
      end
      drain();
`ifdef PIXEL_PACKER_STATS_EN
      check("t7_frame_count", frame_count, 16'(frames));
      check("t7_align_err", align_err, align_exp);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
